// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and constants for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int DEF_AW         = 5;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_ALU_READY  = 2;
    localparam int DEF_LOAD_READY = 3;
    localparam int DEF_CNT_W      = 16;

    // Widest register address a tag can hold; narrower addresses are zero-extended.
    localparam int MAX_AW = 16;

    localparam int STAGE_E = 1;
    localparam int STAGE_M = 2;
    localparam int STAGE_W = 3;

    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] dest;
        logic              wr;
        logic              ld;
    } tag_t;

    function automatic logic is_writer(input tag_t t);
        return t.v & t.wr & (t.dest != '0);
    endfunction

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Youngest-producer match, hazard and forward select for one source.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ALU_READY  = DEF_ALU_READY,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int FW         = $clog2(DEF_DEPTH + 1)
) (
    input  logic                   valid_i,
    input  logic                   use_i,
    input  logic [MAX_AW-1:0]      src_i,
    input  tag_t [DEPTH-1:0]       tags_i,
    output logic                   hazard_o,
    output logic [FW-1:0]          sel_o
);

    logic [DEPTH-1:0] w_hit;
    logic [DEPTH-1:0] w_first;
    logic [DEPTH-1:0] w_haz;
    logic [DEPTH:0]   w_seen;
    logic [FW-1:0]    w_sel_acc [DEPTH+1];

    assign w_seen[0]    = 1'b0;
    assign w_sel_acc[0] = '0;

    // Array index k holds stage k+1; the producer will sit in stage k+2 when
    // the decoding instruction reaches execute.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam int NEXT      = k + 2;
        localparam bit LD_LATE   = (NEXT < LOAD_READY);
        localparam bit ALU_LATE  = (NEXT < ALU_READY);
        localparam bit IN_WINDOW = (NEXT <= DEPTH);

        assign w_hit[k]   = use_i & valid_i & is_writer(tags_i[k])
                          & (tags_i[k].dest == src_i);
        assign w_first[k] = w_hit[k] & ~w_seen[k];
        assign w_seen[k+1] = w_seen[k] | w_hit[k];
        assign w_haz[k]   = w_first[k] & (tags_i[k].ld ? LD_LATE : ALU_LATE);

        assign w_sel_acc[k+1] = w_sel_acc[k]
            | ({FW{w_first[k] & ~w_haz[k] & IN_WINDOW}} & FW'(NEXT));
    end

    assign hazard_o = |w_haz;
    assign sel_o    = w_sel_acc[DEPTH];

endmodule : hazard_match
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage hazard detection, stall/flush and forward selects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int AW         = DEF_AW,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int ALU_READY  = DEF_ALU_READY,
    parameter  int LOAD_READY = DEF_LOAD_READY,
    parameter  int CNT_W      = DEF_CNT_W,
    localparam int FW         = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             valid_D,
    input  logic [AW-1:0]    rsD,
    input  logic [AW-1:0]    rtD,
    input  logic             use_rs_D,
    input  logic             use_rt_D,
    input  logic [AW-1:0]    dest_D,
    input  logic             regwrite_D,
    input  logic             load_D,
    input  logic             pcsrc_D,
    input  logic             ext_stall,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [FW-1:0]    fwdA_E,
    output logic [FW-1:0]    fwdB_E,
    output logic [CNT_W-1:0] stall_cnt
);

    tag_t [DEPTH-1:0] tags_q;
    tag_t [DEPTH-1:0] tags_d;
    logic [FW-1:0]    fwdA_q, fwdA_d;
    logic [FW-1:0]    fwdB_q, fwdB_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             haz_a, haz_b, hazard;
    logic [FW-1:0]    sel_a, sel_b;

    hazard_match #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY),
        .FW         (FW)
    ) u_match_rs (
        .valid_i  (valid_D),
        .use_i    (use_rs_D),
        .src_i    (MAX_AW'(rsD)),
        .tags_i   (tags_q),
        .hazard_o (haz_a),
        .sel_o    (sel_a)
    );

    hazard_match #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY),
        .FW         (FW)
    ) u_match_rt (
        .valid_i  (valid_D),
        .use_i    (use_rt_D),
        .src_i    (MAX_AW'(rtD)),
        .tags_i   (tags_q),
        .hazard_o (haz_b),
        .sel_o    (sel_b)
    );

    assign hazard = haz_a | haz_b;
    assign stallF = hazard | ext_stall;
    assign stallD = hazard | ext_stall;
    // A hazard stall outranks a taken branch: decode is held, so it is not squashed.
    assign flushD = pcsrc_D & ~stallD;
    assign flushE = (hazard & ~ext_stall) | flushD;

    assign tags_d[STAGE_E-1] = '{v:    valid_D & ~flushE,
                                 dest: MAX_AW'(dest_D),
                                 wr:   regwrite_D,
                                 ld:   load_D};

    for (genvar k = 1; k < DEPTH; k++) begin : g_shift
        assign tags_d[k] = tags_q[k-1];
    end

    assign fwdA_d = flushE ? '0 : sel_a;
    assign fwdB_d = flushE ? '0 : sel_b;
    assign cnt_d  = (hazard && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tags_q <= '0;
            fwdA_q <= '0;
            fwdB_q <= '0;
            cnt_q  <= '0;
        end else if (!ext_stall) begin
            tags_q <= tags_d;
            fwdA_q <= fwdA_d;
            fwdB_q <= fwdB_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fwdA_E    = fwdA_q;
    assign fwdB_E    = fwdB_q;
    assign stall_cnt = cnt_q;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        reset;
    logic        valid_D;
    logic [4:0]  rsD, rtD, dest_D;
    logic        use_rs_D, use_rt_D, regwrite_D, load_D, pcsrc_D, ext_stall;
    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  fwdA_E, fwdB_E;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard dut (
        .CLK        (CLK),
        .reset      (reset),
        .valid_D    (valid_D),
        .rsD        (rsD),
        .rtD        (rtD),
        .use_rs_D   (use_rs_D),
        .use_rt_D   (use_rt_D),
        .dest_D     (dest_D),
        .regwrite_D (regwrite_D),
        .load_D     (load_D),
        .pcsrc_D    (pcsrc_D),
        .ext_stall  (ext_stall),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .fwdA_E     (fwdA_E),
        .fwdB_E     (fwdB_E),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one decode-stage instruction and let combinational outputs settle.
    task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic wr, input logic ld);
        valid_D = v;  rsD = rs;  rtD = rt;  use_rs_D = urs;  use_rt_D = urt;
        dest_D = dst; regwrite_D = wr; load_D = ld;
        #1;
    endtask

    initial begin
        reset = 1'b0; pcsrc_D = 1'b0; ext_stall = 1'b0;
        dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("rst_stallF", stallF, 0);
        check("rst_flushD", flushD, 0);
        check("rst_flushE", flushE, 0);
        check("rst_fwdA", fwdA_E, 0);
        check("rst_fwdB", fwdB_E, 0);
        check("rst_cnt", stall_cnt, 0);

        // ALU producer followed by consumer
        dec(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        dec(1, 5'd3, 5'd7, 1, 1, 5'd6, 1, 0);
        check("alu_nostall", stallD, 0);
        tick();
        check("alu_fwdA", fwdA_E, 2);
        check("alu_fwdB", fwdB_E, 0);

        // Load-use: one bubble, then forward from W
        dec(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        dec(1, 5'd5, 5'd6, 1, 1, 5'd8, 1, 0);
        check("lu_stallF", stallF, 1);
        check("lu_stallD", stallD, 1);
        check("lu_flushE", flushE, 1);
        check("lu_flushD", flushD, 0);
        tick();
        check("lu_fwdA_bubble", fwdA_E, 0);
        check("lu_release", stallD, 0);
        check("lu_cnt", stall_cnt, 1);
        tick();
        check("lu_fwdA", fwdA_E, 3);
        check("lu_fwdB_beyond", fwdB_E, 0);

        // Writer to r0 never forwards or stalls
        dec(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        tick();
        dec(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);
        check("r0_nostall", stallD, 0);
        tick();
        check("r0_fwdA", fwdA_E, 0);
        check("r0_fwdB", fwdB_E, 0);

        // Two in-flight writers of r4: the youngest wins
        dec(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
        tick();
        dec(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
        tick();
        dec(1, 5'd10, 5'd4, 1, 1, 5'd13, 1, 0);
        check("dbl_nostall", stallD, 0);
        tick();
        check("dbl_fwdB", fwdB_E, 2);
        check("dbl_fwdA", fwdA_E, 0);

        // ext_stall held over a load-use hazard
        dec(1, 5'd4, 5'd0, 1, 0, 5'd5, 1, 1);
        tick();
        check("ext_pre_fwdA", fwdA_E, 3);
        dec(1, 5'd5, 5'd0, 1, 0, 5'd11, 1, 0);
        check("ext_haz", stallD, 1);
        check("ext_haz_flushE", flushE, 1);
        ext_stall = 1'b1;
        #1;
        check("ext_flushE", flushE, 0);
        check("ext_stallF", stallF, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ext_fwdA_frozen", fwdA_E, 3);
            check("ext_cnt_frozen", stall_cnt, 1);
            check("ext_haz_held", stallD, 1);
        end
        ext_stall = 1'b0;
        #1;
        check("ext_rel_flushE", flushE, 1);
        tick();
        check("ext_rel_cnt", stall_cnt, 2);
        check("ext_rel_stall", stallD, 0);
        check("ext_rel_fwd_bubble", fwdA_E, 0);
        tick();
        check("ext_rel_fwdA", fwdA_E, 3);

        // Reset in the middle of a load-use stall
        dec(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1);
        tick();
        dec(1, 5'd7, 5'd0, 1, 0, 5'd14, 1, 0);
        check("rst_mid_haz", stallD, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_stallD", stallD, 0);
        check("rst_mid_flushE", flushE, 0);
        check("rst_mid_cnt", stall_cnt, 0);
        check("rst_mid_fwdA", fwdA_E, 0);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_nohaz", stallD, 0);

        // Taken branch without a hazard
        pcsrc_D = 1'b1;
        dec(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
        check("br_flushD", flushD, 1);
        check("br_flushE", flushE, 1);
        check("br_stallF", stallF, 0);
        pcsrc_D = 1'b0;
        tick();

        // Taken branch coinciding with a load-use hazard
        dec(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 1);
        tick();
        pcsrc_D = 1'b1;
        dec(1, 5'd12, 5'd0, 1, 0, 5'd0, 0, 0);
        check("brhaz_flushD", flushD, 0);
        check("brhaz_flushE", flushE, 1);
        check("brhaz_stallD", stallD, 1);
        pcsrc_D = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
